// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter sequencing single-word
// transactions onto the bussystem CPU port, with watchdog.
module mem_access_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [14:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic        err0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [14:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata1,
  output logic [14:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_w,
  output logic        bus_readstart,
  input  logic [31:0] bus_rdata,
  input  logic        bus_readrdy,
  input  logic        bus_saverdy,
  output logic        busy,
  output logic        grant
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic            we_q, we_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            grant_d, busy_d;
  logic            bus_w_d, rs_d;
  logic            ack0_d, ack1_d;
  logic            err0_d, err1_d;
  logic [14:0]     addr_d;
  logic [31:0]     wdata_d;
  logic [31:0]     rdata0_d, rdata1_d;
  logic            rdy, tmo, pick, pick_we;
  logic [31:0]     cap;

  // Watched ready depends on direction; ties go away from last grant.
  assign rdy     = we_q ? bus_saverdy : bus_readrdy;
  assign tmo     = (timer_q == TW'(TIMEOUT - 1));
  assign pick    = (req0 && req1) ? ~last_q : req1;
  assign pick_we = pick ? we1 : we0;
  assign cap     = we_q ? 32'd0 : bus_rdata;

  // Next-state and next-output logic for every registered signal.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    we_d     = we_q;
    timer_d  = timer_q;
    grant_d  = grant;
    addr_d   = bus_addr;
    wdata_d  = bus_wdata;
    bus_w_d  = 1'b0;
    rs_d     = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = err0;
    err1_d   = err1;
    rdata0_d = rdata0;
    rdata1_d = rdata1;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d = pick;
          we_d    = pick_we;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          bus_w_d = pick_we;
          rs_d    = ~pick_we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (rdy || tmo) begin
          state_d = DONE;
          if (grant) begin
            ack1_d   = 1'b1;
            err1_d   = ~rdy;
            rdata1_d = rdy ? cap : 32'd0;
          end else begin
            ack0_d   = 1'b1;
            err0_d   = ~rdy;
            rdata0_d = rdy ? cap : 32'd0;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: begin
        last_d  = grant;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and all outputs registered; reset drops any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      we_q          <= 1'b0;
      timer_q       <= '0;
      grant         <= 1'b0;
      busy          <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_w         <= 1'b0;
      bus_readstart <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      err0          <= 1'b0;
      err1          <= 1'b0;
      rdata0        <= '0;
      rdata1        <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      we_q          <= we_d;
      timer_q       <= timer_d;
      grant         <= grant_d;
      busy          <= busy_d;
      bus_addr      <= addr_d;
      bus_wdata     <= wdata_d;
      bus_w         <= bus_w_d;
      bus_readstart <= rs_d;
      ack0          <= ack0_d;
      ack1          <= ack1_d;
      err0          <= err0_d;
      err1          <= err1_d;
      rdata0        <= rdata0_d;
      rdata1        <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed plus random
// transactions against a transaction-level model.
module tb_mem_access_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [14:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [14:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_w, bus_readstart, busy, grant;
  logic [31:0] bus_rdata = 0;
  logic        bus_readrdy = 0, bus_saverdy = 0;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_last;
  logic [31:0] m_rdata [2];
  bit          m_err [2];

  mem_access_arbiter #(.TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_w(bus_w), .bus_readstart(bus_readstart),
    .bus_rdata(bus_rdata), .bus_readrdy(bus_readrdy),
    .bus_saverdy(bus_saverdy),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_held();
    chk("rdata0", rdata0, m_rdata[0]);
    chk("rdata1", rdata1, m_rdata[1]);
    chk("err0", 32'(err0), 32'(m_err[0]));
    chk("err1", 32'(err1), 32'(m_err[1]));
  endtask

  // One transaction. Entered and left in an IDLE cycle.
  // dly = WAIT index on which ready rises (>= TO: never).
  task automatic txn(input bit r0, input bit r1,
                     input bit w0, input bit w1,
                     input logic [14:0] a0, input logic [14:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input int dly, input logic [31:0] rd,
                     input bit drop_w, input bit rdy_pre);
    bit          w, we_s, hit, oth;
    logic [14:0] a_s;
    logic [31:0] d_s, exp_rd;
    int          nwait;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ack0", 32'(ack0), 0);
    chk("idle_ack1", 32'(ack1), 0);
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    bus_readrdy = rdy_pre; bus_saverdy = rdy_pre;
    bus_rdata = 32'hBAD0BAD0;
    w    = (r0 && r1) ? !m_last : r1;
    we_s = w ? w1 : w0;
    a_s  = w ? a1 : a0;
    d_s  = w ? d1 : d0;
    @(posedge clk); #1;
    chk("iss_grant", 32'(grant), 32'(w));
    chk("iss_busy", 32'(busy), 1);
    chk("iss_w", 32'(bus_w), 32'(we_s));
    chk("iss_rs", 32'(bus_readstart), 32'(!we_s));
    chk("iss_addr", 32'(bus_addr), 32'(a_s));
    chk("iss_wdata", bus_wdata, d_s);
    we0 = 1'($urandom); we1 = 1'($urandom);
    addr0 = 15'($urandom); addr1 = 15'($urandom);
    wdata0 = $urandom; wdata1 = $urandom;
    hit = 0;
    nwait = 0;
    for (int k = 0; k < TO; k++) begin
      @(posedge clk); #1;
      nwait++;
      chk("wait_w", 32'(bus_w), 0);
      chk("wait_rs", 32'(bus_readstart), 0);
      chk("wait_busy", 32'(busy), 1);
      chk("wait_ack0", 32'(ack0), 0);
      chk("wait_ack1", 32'(ack1), 0);
      chk("wait_addr", 32'(bus_addr), 32'(a_s));
      chk("wait_wdata", bus_wdata, d_s);
      if (drop_w && k == 0) begin
        if (w) req1 = 0; else req0 = 0;
      end
      hit = (k == dly);
      oth = 1'($urandom);
      bus_readrdy = we_s ? oth : hit;
      bus_saverdy = we_s ? hit : oth;
      bus_rdata   = hit ? rd : $urandom;
      if (hit) break;
    end
    exp_rd = (hit && !we_s) ? rd : 32'd0;
    chk("n_wait", 32'(nwait), hit ? 32'(dly + 1) : 32'(TO));
    @(posedge clk); #1;
    bus_readrdy = 0; bus_saverdy = 0;
    m_rdata[w] = exp_rd;
    m_err[w]   = !hit;
    m_last     = w;
    chk("done_ack0", 32'(ack0), 32'(!w));
    chk("done_ack1", 32'(ack1), 32'(w));
    chk("done_busy", 32'(busy), 1);
    chk("done_addr", 32'(bus_addr), 32'(a_s));
    chk_held();
    @(posedge clk); #1;
    chk("idle_grant", 32'(grant), 32'(w));
    chk("idle_addr", 32'(bus_addr), 32'(a_s));
    chk_held();
  endtask

  initial begin
    bit r0, r1;
    m_last = 1; m_rdata[0] = 0; m_rdata[1] = 0;
    m_err[0] = 0; m_err[1] = 0;
    #2 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_addr", 32'(bus_addr), 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_w", 32'(bus_w), 0);
    chk("rst_rs", 32'(bus_readstart), 0);
    chk_held();
    rst = 1;
    @(posedge clk); #1;

    txn(1, 0, 0, 0, 15'h0010, 15'h0, 0, 0,
        0, 32'hDEADBEEF, 0, 0);
    txn(0, 1, 0, 1, 15'h0, 15'h7FFF, 0, 32'h12345678,
        5, $urandom, 0, 0);
    for (int i = 0; i < 4; i++)
      txn(1, 1, 1'($urandom), 1'($urandom),
          15'($urandom), 15'($urandom), $urandom, $urandom,
          0, $urandom, 0, 0);
    txn(1, 0, 0, 0, 15'h0042, 0, 0, 0, TO, $urandom, 0, 0);
    txn(1, 0, 0, 0, 15'h0043, 0, 0, 0, TO - 1,
        32'hCAFEF00D, 0, 0);
    txn(1, 0, 0, 0, 15'h0044, 0, 0, 0, 0,
        32'h0BADC0DE, 1, 1);
    req0 = 0; req1 = 0;
    @(posedge clk); #1;

    req0 = 1; we0 = 0; addr0 = 15'h0123;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_ack0", 32'(ack0), 0);
    chk("arst_addr", 32'(bus_addr), 0);
    chk("arst_wdata", bus_wdata, 0);
    chk("arst_w", 32'(bus_w), 0);
    chk("arst_rs", 32'(bus_readstart), 0);
    m_last = 1; m_rdata[0] = 0; m_rdata[1] = 0;
    m_err[0] = 0; m_err[1] = 0;
    chk_held();
    req0 = 0;
    @(posedge clk); #1;
    rst = 1;
    bus_readrdy = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_ack0", 32'(ack0), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    bus_readrdy = 0;
    txn(1, 1, 0, 0, 15'h0011, 15'h0022, 0, 0,
        0, $urandom, 0, 0);

    for (int i = 0; i < 30; i++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1;
      txn(r0, r1, 1'($urandom), 1'($urandom),
          15'($urandom), 15'($urandom), $urandom, $urandom,
          $urandom_range(0, TO + 1), $urandom,
          1'($urandom), 1'($urandom));
    end
    req0 = 0; req1 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("end_busy", 32'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
